key_detect: RTL

- Downstream consumer of the camera pixel stream; runs on the same quarter-rate clock as the camera controller.
- Per frame, counts dark pixels inside each of NUM_KEYS vertical key strips within a fixed row band.
- Thresholds and debounces those counts into a key-pressed bitmap for the sound and LED debug logic.
- Frame-rate output only; no frame buffering.

---
 rtl/key_pkg.sv | 25 ++
 rtl/key_strip_counter.sv | 29 ++
 rtl/key_detect.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key strip detector: pixel field layout, FSM encoding
// and counter width.
package key_pkg;

    localparam int PIX_W  = 9;
    localparam int R_HI   = 8;
    localparam int R_LO   = 6;
    localparam int G_HI   = 5;
    localparam int G_LO   = 3;
    localparam int B_HI   = 2;
    localparam int B_LO   = 0;

    localparam int LUMA_W = 5;
    localparam int CNT_W  = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_EVAL  = 2'd2;

    // r+g+b of three 3-bit channels, 0..21
    function automatic logic [LUMA_W-1:0] pix_luma(input logic [PIX_W-1:0] p);
        return LUMA_W'(p[R_HI:R_LO]) + LUMA_W'(p[G_HI:G_LO]) + LUMA_W'(p[B_HI:B_LO]);
    endfunction

endpackage

// File: rtl/key_strip_counter.sv
// Saturating dark-pixel counter for one key strip, with synchronous clear and
// a strict greater-than threshold flag.
module key_strip_counter
    import key_pkg::*;
#(
    parameter logic [CNT_W-1:0] THRESH = CNT_W'(400)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic above
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign above = (count_reg > THRESH);

endmodule

// File: rtl/key_detect.sv
// Per-frame key strip detector: counts dark pixels per strip inside a row band,
// then thresholds and debounces them into a key-pressed bitmap.
module key_detect
    import key_pkg::*;
#(
    parameter int H_RES    = 320,
    parameter int V_RES    = 240,
    parameter int NUM_KEYS = 8,
    parameter int KEY_W    = 40,
    parameter int Y_TOP    = 160,
    parameter int Y_BOT    = 220,
    parameter int LUMA_TH  = 6,
    parameter int CNT_TH   = 400
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                pix_valid,
    input  logic [PIX_W-1:0]    pix_data,
    output logic [NUM_KEYS-1:0] keys,
    output logic                keys_valid,
    output logic                busy
);

    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);
    localparam int SW = $clog2(NUM_KEYS + 1);
    localparam int OW = $clog2(KEY_W);
    localparam int EW = $clog2(NUM_KEYS + 1);

    localparam logic [XW-1:0]     X_LAST    = XW'(H_RES - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(V_RES - 1);
    localparam logic [YW-1:0]     Y_TOP_V   = YW'(Y_TOP);
    localparam logic [YW-1:0]     Y_BOT_V   = YW'(Y_BOT);
    localparam logic [OW-1:0]     O_LAST    = OW'(KEY_W - 1);
    localparam logic [SW-1:0]     NK_V      = SW'(NUM_KEYS);
    localparam logic [EW-1:0]     E_LAST    = EW'(NUM_KEYS);
    localparam logic [LUMA_W-1:0] LUMA_TH_V = LUMA_W'(LUMA_TH);

    logic [1:0]    state_reg;
    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    logic [SW-1:0] strip_reg;
    logic [OW-1:0] off_reg;
    logic [EW-1:0] eval_reg;
    logic          keys_valid_reg;

    logic          accept;
    logic          count_ok;
    logic          clr_cnt;
    logic [NUM_KEYS-1:0] above;

    // frame_start wins over a coincident pixel
    assign accept   = (state_reg == ST_ACCUM) && pix_valid && !frame_start;
    assign count_ok = accept
                      && (y_reg >= Y_TOP_V) && (y_reg <= Y_BOT_V)
                      && (strip_reg < NK_V)
                      && (pix_luma(pix_data) < LUMA_TH_V);
    assign clr_cnt  = frame_start && (state_reg != ST_EVAL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            x_reg          <= '0;
            y_reg          <= '0;
            strip_reg      <= '0;
            off_reg        <= '0;
            eval_reg       <= '0;
            keys_valid_reg <= 1'b0;
        end else begin
            keys_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_reg <= ST_ACCUM;
                        x_reg     <= '0;
                        y_reg     <= '0;
                        strip_reg <= '0;
                        off_reg   <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (frame_start) begin
                        x_reg     <= '0;
                        y_reg     <= '0;
                        strip_reg <= '0;
                        off_reg   <= '0;
                    end else if (pix_valid) begin
                        if (x_reg == X_LAST) begin
                            x_reg     <= '0;
                            strip_reg <= '0;
                            off_reg   <= '0;
                            if (y_reg == Y_LAST) begin
                                y_reg     <= '0;
                                eval_reg  <= '0;
                                state_reg <= ST_EVAL;
                            end else begin
                                y_reg <= y_reg + 1'b1;
                            end
                        end else begin
                            x_reg <= x_reg + 1'b1;
                            // strip index tracked incrementally; parks at NUM_KEYS past the last strip
                            if (off_reg == O_LAST) begin
                                off_reg <= '0;
                                if (strip_reg != NK_V) begin
                                    strip_reg <= strip_reg + 1'b1;
                                end
                            end else begin
                                off_reg <= off_reg + 1'b1;
                            end
                        end
                    end
                end
                ST_EVAL: begin
                    // slots 0..NUM_KEYS-1 evaluate one key each; the final slot publishes
                    if (eval_reg == E_LAST) begin
                        state_reg      <= ST_IDLE;
                        keys_valid_reg <= 1'b1;
                    end else begin
                        eval_reg <= eval_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        logic key_reg;
        logic prev_reg;
        logic eval_hit;

        key_strip_counter #(
            .THRESH(CNT_W'(CNT_TH))
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .clr  (clr_cnt),
            .en   (count_ok && (strip_reg == SW'(gi))),
            .above(above[gi])
        );

        assign eval_hit = (state_reg == ST_EVAL) && (eval_reg == EW'(gi));

        // a key only changes after two consecutive frames agree
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                key_reg  <= 1'b0;
                prev_reg <= 1'b0;
            end else if (eval_hit) begin
                if (above[gi] == prev_reg) begin
                    key_reg <= above[gi];
                end
                prev_reg <= above[gi];
            end
        end

        assign keys[gi] = key_reg;
    end

    assign keys_valid = keys_valid_reg;
    assign busy       = (state_reg == ST_ACCUM) || (state_reg == ST_EVAL);

endmodule
